// File: rtl/nv_nvdla_cmac_pkg.sv
// Shared definitions for the CMAC ping-pong layer controller.
// State encoding and precision defaults live here.
package nv_nvdla_cmac_pkg;

    localparam int          CMAC_PREC_W   = 2;
    localparam logic [1:0]  CMAC_PREC_RST = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10
    } cmac_state_e;

endpackage

// File: rtl/nv_nvdla_cmac_op_en_bit.sv
// One register-group OP_ENABLE flag.
// Set has priority over clear; otherwise the flag holds.
module nv_nvdla_cmac_op_en_bit (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (set_i) begin
            q_d = 1'b1;
        end else if (clr_i) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/nv_nvdla_cmac_pingpong_ctrl.sv
// Ping-pong layer controller: alternates between two register groups,
// launching the datapath with a shadowed copy of the active group's config.
module nv_nvdla_cmac_pingpong_ctrl
    import nv_nvdla_cmac_pkg::*;
#(
    parameter int                PREC_W   = CMAC_PREC_W,
    parameter logic [PREC_W-1:0] PREC_RST = PREC_W'(CMAC_PREC_RST)
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              op_en_trigger_0,
    input  logic              op_en_trigger_1,
    input  logic              op_en_wdata,
    input  logic              conv_mode_0,
    input  logic              conv_mode_1,
    input  logic [PREC_W-1:0] proc_precision_0,
    input  logic [PREC_W-1:0] proc_precision_1,
    input  logic              dp_done,
    output logic              op_en_0,
    output logic              op_en_1,
    output logic              consumer,
    output logic              dp_start,
    output logic              dp_busy,
    output logic              dp_conv_mode,
    output logic [PREC_W-1:0] dp_proc_precision,
    output logic [1:0]        done_intr
);

    cmac_state_e       state_q, state_d;
    logic              cons_q, cons_d;
    logic              mode_q, mode_d;
    logic [PREC_W-1:0] prec_q, prec_d;
    logic [1:0]        intr_q, intr_d;
    logic              done_acc;
    logic [1:0]        op_en;
    logic [1:0]        trig;
    logic [1:0]        set_v;
    logic [1:0]        clr_v;

    assign trig = {op_en_trigger_1, op_en_trigger_0};

    always_comb begin
        state_d  = state_q;
        cons_d   = cons_q;
        mode_d   = mode_q;
        prec_d   = prec_q;
        done_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (op_en[cons_q]) begin
                    state_d = ST_START;
                    mode_d  = cons_q ? conv_mode_1 : conv_mode_0;
                    prec_d  = cons_q ? proc_precision_1 : proc_precision_0;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (dp_done) begin
                    state_d  = ST_IDLE;
                    cons_d   = ~cons_q;
                    done_acc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        intr_d = done_acc ? (2'b01 << cons_q) : 2'b00;
    end

    // A write-0 to the running group is dropped so the layer cannot be pulled
    for (genvar g = 0; g < 2; g++) begin : g_op_en
        logic own;
        assign own      = (cons_q == 1'(g));
        assign set_v[g] = trig[g] & op_en_wdata;
        assign clr_v[g] = (trig[g] & ~op_en_wdata & ~(own & dp_busy))
                        | (done_acc & own);

        nv_nvdla_cmac_op_en_bit u_bit (
            .clk_i  (nvdla_core_clk),
            .rst_ni (nvdla_core_rstn),
            .set_i  (set_v[g]),
            .clr_i  (clr_v[g]),
            .q_o    (op_en[g])
        );
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= ST_IDLE;
            cons_q  <= 1'b0;
            mode_q  <= 1'b0;
            prec_q  <= PREC_RST;
            intr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cons_q  <= cons_d;
            mode_q  <= mode_d;
            prec_q  <= prec_d;
            intr_q  <= intr_d;
        end
    end

    assign op_en_0           = op_en[0];
    assign op_en_1           = op_en[1];
    assign consumer          = cons_q;
    assign dp_start          = (state_q == ST_START);
    assign dp_busy           = (state_q != ST_IDLE);
    assign dp_conv_mode      = mode_q;
    assign dp_proc_precision = prec_q;
    assign done_intr         = intr_q;

endmodule

// File: doc/nv_nvdla_cmac_pingpong_ctrl.md
NV_NVDLA_CMAC_PINGPONG_CTRL -- requirements
Module: nv_nvdla_cmac_pingpong_ctrl

Interface
REQ-001 SHALL provide parameter PREC_W, default 2, width of the proc_precision field.
REQ-002 SHALL provide parameter PREC_RST, default 2'b01, reset value of dp_proc_precision.
REQ-003 SHALL have port nvdla_core_clk  in  1  sole clock; all flops rise-edge on it.
REQ-004 SHALL have port nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port op_en_trigger_0  in  1  group-0 OP_ENABLE write strobe.
REQ-006 SHALL have port op_en_trigger_1  in  1  group-1 OP_ENABLE write strobe.
REQ-007 SHALL have port op_en_wdata  in  1  bit 0 of the register write data.
REQ-008 SHALL have ports conv_mode_0 and conv_mode_1  in  1 each  per-group MISC_CFG conv_mode.
REQ-009 SHALL have ports proc_precision_0 and proc_precision_1  in  PREC_W each  per-group MISC_CFG proc_precision.
REQ-010 SHALL have port dp_done  in  1  single-cycle datapath completion pulse.
REQ-011 SHALL have ports op_en_0 and op_en_1  out  1 each  per-group op_en readback to the register groups.
REQ-012 SHALL have port consumer  out  1  index of the group being consumed next or now.
REQ-013 SHALL have port dp_start  out  1  single-cycle launch pulse to the datapath.
REQ-014 SHALL have ports dp_conv_mode  out  1  and dp_proc_precision  out  PREC_W  shadowed config for the active layer.
REQ-015 SHALL have port dp_busy  out  1  high from START through BUSY.
REQ-016 SHALL have port done_intr  out  2  one-cycle completion pulse per group.

Function
REQ-017 A trigger with op_en_wdata=1 SHALL set op_en_g at the next edge; with op_en_wdata=0 SHALL clear it, unless g is the consumer and state is START or BUSY, in which case the write SHALL be ignored.
REQ-018 The FSM SHALL have states IDLE, START and BUSY.
REQ-019 IDLE->START SHALL occur at the first edge where op_en[consumer]=1; on that edge conv_mode/proc_precision of the consumer group SHALL be latched into dp_conv_mode/dp_proc_precision.
REQ-020 dp_start SHALL be high exactly one cycle in START; a trigger in cycle N therefore yields dp_start in cycle N+2 when IDLE.
REQ-021 START->BUSY SHALL be unconditional after one cycle.
REQ-022 In BUSY, dp_done SHALL cause: BUSY->IDLE, op_en[consumer] cleared, consumer toggled, done_intr[old consumer] high the next cycle only.
REQ-023 dp_done outside BUSY SHALL be ignored, including a dp_done in START.
REQ-024 If dp_done coincides with a write-1 trigger to the same group, the set SHALL win and op_en stays 1; consumer still toggles.
REQ-025 Triggers to the non-consumer group SHALL be accepted in any state without disturbing the running layer.
REQ-026 dp_conv_mode and dp_proc_precision SHALL stay constant from START until the next IDLE->START, regardless of register writes.
REQ-027 Back-to-back: if op_en of the new consumer is already 1 on return to IDLE, START SHALL follow one cycle later (one idle cycle minimum).

Reset
REQ-028 On reset, state=IDLE, consumer=0, op_en_0=op_en_1=0, dp_start=0, dp_busy=0, done_intr=0, dp_conv_mode=0, dp_proc_precision=PREC_RST.
REQ-029 Reset mid-layer SHALL abandon the layer with no done_intr; dp_done arriving after reset release while IDLE SHALL be ignored.

Structure
REQ-030 FSM state encoding, PREC_W and PREC_RST SHALL live in shared package nv_nvdla_cmac_pkg.
REQ-031 The per-group op_en flag (set/clear/hold, set-priority) SHALL be one sub-module, nv_nvdla_cmac_op_en_bit, instantiated twice.

Verification
REQ-032 Reset; trigger g0 wdata=1 at cycle 10 -> op_en_0=1 at 11, dp_start at 12, dp_busy 12 onward.
REQ-033 g0 conv_mode=1, precision=2'b10 launched; rewrite g0 cfg to 0/2'b00 during BUSY -> dp outputs stay 1/2'b10; dp_done -> done_intr=2'b01 one cycle, consumer=1, op_en_0=0.
REQ-034 Arm g0 and g1 then run -> g0 runs, done, g1 starts exactly 2 cycles after g0 dp_done, done_intr 2'b01 then 2'b10.
REQ-035 Write 0 to g0 while g0 BUSY -> op_en_0 stays 1; write 0 to armed g1 -> op_en_1=0, no launch of g1.
REQ-036 dp_done same cycle as g0 write-1 trigger -> op_en_0=1, consumer=1; dp_done while IDLE -> no state/intr change.
REQ-037 Assert nvdla_core_rstn low during BUSY -> all outputs at reset values immediately, no done_intr after release.
